// File: rtl/cpu16_ctrl.sv
// Multicycle control unit for the 16-bit CPU: fetch/decode/execute sequencing,
// memory handshake, register-file strobes, one-hot ALU control and PC updates.
module cpu16_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA,
  input  logic [15:0] A_DATA,
  output logic [3:0]  RA,
  output logic [3:0]  RB,
  output logic [3:0]  RD,
  output logic        RF_WE,
  output logic        RF_WSEL,
  output logic [3:0]  ICNT,
  output logic [15:0] PC,
  output logic        HALTED,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BEZ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  logic [15:0] ir;
  logic [15:0] pc;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [3:0]  icnt;
  logic        alu_we;
  logic        halted;
  logic [3:0]  op;
  logic [15:0] br_target;
  logic        ld_ack;

  assign op = ir[15:12];
  // PC already points past the branch, so the offset is relative to PC+1.
  assign br_target = pc + {{8{ir[11]}}, ir[11:8], ir[3:0]};
  // The load write-back has to coincide with the ack cycle, when MEM_RDATA is valid.
  assign ld_ack = (state == S_MEM) && MEM_ACK && (op == OP_LD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= 16'h0000;
      req    <= 1'b0;
      we     <= 1'b0;
      addr   <= RESET_PC;
      icnt   <= 4'b0000;
      alu_we <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!req) begin
            req  <= 1'b1;
            we   <= 1'b0;
            addr <= pc;
          end else if (MEM_ACK) begin
            ir    <= MEM_RDATA;
            pc    <= pc + 16'd1;
            req   <= 1'b0;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXEC;
          case (op)
            OP_ADD:  begin icnt <= 4'b0001; alu_we <= 1'b1; end
            OP_SUB:  begin icnt <= 4'b0010; alu_we <= 1'b1; end
            OP_AND:  begin icnt <= 4'b0100; alu_we <= 1'b1; end
            OP_OR:   begin icnt <= 4'b1000; alu_we <= 1'b1; end
            default: begin icnt <= 4'b0000; alu_we <= 1'b0; end
          endcase
        end
        S_EXEC: begin
          icnt   <= 4'b0000;
          alu_we <= 1'b0;
          case (op)
            OP_LD, OP_ST: begin
              req   <= 1'b1;
              we    <= (op == OP_ST);
              addr  <= A_DATA;
              state <= S_MEM;
            end
            OP_JMP: begin
              pc    <= A_DATA;
              req   <= 1'b1;
              we    <= 1'b0;
              addr  <= A_DATA;
              state <= S_FETCH;
            end
            OP_BEZ: begin
              req   <= 1'b1;
              we    <= 1'b0;
              state <= S_FETCH;
              if (A_DATA == 16'h0000) begin
                pc   <= br_target;
                addr <= br_target;
              end else begin
                addr <= pc;
              end
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              req   <= 1'b1;
              we    <= 1'b0;
              addr  <= pc;
              state <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (MEM_ACK) begin
            req   <= 1'b1;
            we    <= 1'b0;
            addr  <= pc;
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign MEM_REQ   = req;
  assign MEM_WE    = we;
  assign MEM_ADDR  = addr;
  assign RA        = ir[7:4];
  assign RB        = ir[3:0];
  assign RD        = ir[11:8];
  assign RF_WE     = alu_we | ld_ack;
  assign RF_WSEL   = (state == S_MEM);
  assign ICNT      = icnt;
  assign PC        = pc;
  assign HALTED    = halted;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_cpu16_ctrl.sv
// Directed bench for cpu16_ctrl: a small memory driver, a queue of expected
// fetch addresses, and per-cycle checks of the control outputs.
module tb_cpu16_ctrl;

  logic        CLK;
  logic        RST;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;
  logic [15:0] A_DATA;
  logic [3:0]  RA;
  logic [3:0]  RB;
  logic [3:0]  RD;
  logic        RF_WE;
  logic        RF_WSEL;
  logic [3:0]  ICNT;
  logic [15:0] PC;
  logic        HALTED;
  logic [2:0]  DBG_STATE;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_fa;

  cpu16_ctrl #(.RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST(RST),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .A_DATA(A_DATA),
    .RA(RA), .RB(RB), .RD(RD),
    .RF_WE(RF_WE), .RF_WSEL(RF_WSEL), .ICNT(ICNT),
    .PC(PC), .HALTED(HALTED), .DBG_STATE(DBG_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the expected fetch address and checks the request now on the bus.
  task automatic fetch_check();
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 16'd1, 16'd0);
      cur_fa = 16'h0000;
    end else begin
      cur_fa = exp_q.pop_front();
    end
    chk("fetch_req", MEM_REQ, 1'b1);
    chk("fetch_addr", MEM_ADDR, cur_fa);
    chk("fetch_we", MEM_WE, 1'b0);
    chk("fetch_state", DBG_STATE, 3'd0);
    chk("fetch_icnt", ICNT, 4'b0000);
    chk("fetch_rf_we", RF_WE, 1'b0);
  endtask

  // From a pending fetch through DECODE; returns at the EXEC sampling point.
  task automatic fetch_to_exec(input logic [15:0] instr, input int fw, input logic [15:0] a);
    logic [15:0] pc_next;
    for (int w = 0; w < fw; w++) begin
      MEM_ACK = 1'b0;
      @(negedge CLK);
      chk("fetch_hold_req", MEM_REQ, 1'b1);
      chk("fetch_hold_addr", MEM_ADDR, cur_fa);
    end
    MEM_ACK = 1'b1;
    MEM_RDATA = instr;
    @(negedge CLK);
    MEM_ACK = 1'b0;
    MEM_RDATA = 16'h0000;
    pc_next = cur_fa + 16'd1;
    chk("decode_state", DBG_STATE, 3'd1);
    chk("decode_req", MEM_REQ, 1'b0);
    chk("decode_icnt", ICNT, 4'b0000);
    chk("decode_rf_we", RF_WE, 1'b0);
    chk("decode_pc", PC, pc_next);
    A_DATA = a;
    @(negedge CLK);
  endtask

  task automatic finish_instr(input logic [15:0] instr, input logic [15:0] a,
                              input int mw, input logic [15:0] mdata);
    logic [3:0]  op;
    logic [3:0]  exp_icnt;
    logic        is_alu;
    logic [15:0] nxt;
    logic [15:0] off;
    op = instr[15:12];
    is_alu = (op >= 4'h1) && (op <= 4'h4);
    exp_icnt = is_alu ? (4'b0001 << (op - 4'h1)) : 4'b0000;
    chk("exec_state", DBG_STATE, 3'd2);
    chk("exec_icnt", ICNT, exp_icnt);
    chk("exec_rf_we", RF_WE, is_alu);
    chk("exec_ra", RA, instr[7:4]);
    chk("exec_req", MEM_REQ, 1'b0);
    if (is_alu) begin
      chk("exec_rd", RD, instr[11:8]);
      chk("exec_wsel", RF_WSEL, 1'b0);
    end
    off = {{8{instr[11]}}, instr[11:8], instr[3:0]};
    nxt = cur_fa + 16'd1;
    if (op == 4'h7) nxt = a;
    if (op == 4'h8 && a == 16'h0000) nxt = cur_fa + 16'd1 + off;
    if (op == 4'hF) begin
      @(negedge CLK);
      chk("halt_flag", HALTED, 1'b1);
      chk("halt_state", DBG_STATE, 3'd4);
      for (int i = 0; i < 4; i++) begin
        MEM_ACK = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("halt_no_req", MEM_REQ, 1'b0);
        chk("halt_no_we", RF_WE, 1'b0);
      end
      MEM_ACK = 1'b0;
      return;
    end
    if (op == 4'h5 || op == 4'h6) begin
      @(negedge CLK);
      chk("mem_req", MEM_REQ, 1'b1);
      chk("mem_addr", MEM_ADDR, a);
      chk("mem_we", MEM_WE, op == 4'h6);
      for (int w = 0; w < mw; w++) begin
        MEM_ACK = 1'b0;
        #1;
        chk("mem_wait_rf_we", RF_WE, 1'b0);
        @(negedge CLK);
        chk("mem_hold_addr", MEM_ADDR, a);
      end
      MEM_ACK = 1'b1;
      MEM_RDATA = mdata;
      #1;
      chk("mem_ack_rf_we", RF_WE, op == 4'h5);
      if (op == 4'h5) begin
        chk("ld_wsel", RF_WSEL, 1'b1);
        chk("ld_rd", RD, instr[11:8]);
      end
    end
    @(negedge CLK);
    MEM_ACK = 1'b0;
    exp_q.push_back(nxt);
    fetch_check();
  endtask

  task automatic run(input logic [15:0] instr, input int fw, input logic [15:0] a,
                     input int mw, input logic [15:0] mdata);
    fetch_to_exec(instr, fw, a);
    finish_instr(instr, a, mw, mdata);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_req", MEM_REQ, 1'b0);
    chk("rst_pc", PC, 16'h0000);
    chk("rst_halted", HALTED, 1'b0);
    chk("rst_icnt", ICNT, 4'b0000);
    chk("rst_rf_we", RF_WE, 1'b0);
    chk("rst_state", DBG_STATE, 3'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    MEM_ACK = 1'b1;          // ack with no request pending must be ignored
    MEM_RDATA = 16'h1FFF;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    @(negedge CLK);
    MEM_ACK = 1'b0;
    chk("post_rst_pc", PC, 16'h0000);
    fetch_check();
  endtask

  initial begin
    RST = 1'b1;
    MEM_ACK = 1'b0;
    MEM_RDATA = 16'h0000;
    A_DATA = 16'h0000;
    @(negedge CLK);
    do_reset();

    run(16'h1312, 0, 16'($urandom_range(0, 65535)), 0, 16'h0);   // ADD at 0
    run(16'h2512, 2, 16'($urandom_range(0, 65535)), 0, 16'h0);   // SUB, 2 fetch waits
    run(16'h5470, 0, 16'h0100, 1, 16'hBEEF);                     // LD
    run(16'h6072, 1, 16'h0200, 0, 16'h0);                        // ST
    run(16'h7010, 0, 16'h0010, 0, 16'h0);                        // JMP 0x10
    run(16'h8F1E, 0, 16'h0000, 0, 16'h0);                        // BEZ taken -> 0x0F
    run(16'h7010, 0, 16'h0010, 0, 16'h0);                        // back to 0x10
    run(16'h8F1E, 0, 16'h0001, 0, 16'h0);                        // not taken -> 0x11
    run(16'h7000, 0, 16'h2000, 0, 16'h0);                        // JMP 0x2000
    run(16'h9123, 0, 16'h0000, 0, 16'h0);                        // unknown op = NOP
    run(16'h3ABC, $urandom_range(0, 3), 16'h0, 0, 16'h0);        // AND
    run(16'h4DEF, $urandom_range(0, 3), 16'h0, 0, 16'h0);        // OR
    run(16'h7000, 0, 16'hFFFF, 0, 16'h0);                        // JMP 0xFFFF
    run(16'h0000, 0, 16'h0000, 0, 16'h0);                        // NOP wraps to 0
    run(16'h8015, 0, 16'h0000, 0, 16'h0);                        // BEZ +5 -> 6
    run(16'hF000, 0, 16'h0000, 0, 16'h0);                        // HALT

    do_reset();
    fetch_to_exec(16'h5470, 0, 16'h0100);
    chk("abort_exec_rf_we", RF_WE, 1'b0);
    @(negedge CLK);
    chk("abort_mem_req", MEM_REQ, 1'b1);
    MEM_ACK = 1'b0;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_req_drop", MEM_REQ, 1'b0);
    chk("abort_pc", PC, 16'h0000);
    chk("abort_rf_we", RF_WE, 1'b0);
    MEM_ACK = 1'b1;
    #1;
    chk("abort_ack_rf_we", RF_WE, 1'b0);
    MEM_ACK = 1'b0;
    @(negedge CLK);
    do_reset();
    run(16'h1312, 0, 16'h0, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
